// File: rtl/cnc_pkg.sv
// Shared definitions for the CNC segment feeder and its FIFO.
package cnc_pkg;

    localparam int unsigned NX_W            = 8;
    localparam int unsigned DRV_BUF_DEPTH   = 4;
    localparam int unsigned DRV_CLK1_PERIOD = 100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_LIMIT  = 3'd4
    } feeder_state_e;

    // Largest of three cycle counts, used to size the phase timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cnc_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and single-cycle flush.
module cnc_sync_fifo
    import cnc_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = NX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign empty_c = (count_q == '0);
    assign count_o = count_q;

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n)
                                     !(push_i && !pop_i && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(pop_i && count_q == '0));

endmodule

// File: rtl/cnc_segment_feeder.sv
// Queues host segment step counts and strobes them one at a time into the pulse driver.
module cnc_segment_feeder
    import cnc_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned WR_HIGH_CYC = 128,
    parameter int unsigned HOLD_CYC    = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_valid,
    input  logic [NX_W-1:0]          host_data,
    output logic                     host_ready,
    input  logic                     drv_full,
    input  logic                     ls,
    input  logic                     clear_fault,
    output logic [NX_W-1:0]          Nx,
    output logic                     WR,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         seg_count,
    output logic                     fault,
    output logic                     busy
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned MAX_CYC = max3(SETUP_CYC, WR_HIGH_CYC, HOLD_CYC);
    localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

    feeder_state_e   state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [NX_W-1:0] nx_q, nx_d;
    logic            wr_q, wr_d;
    logic            fault_q, fault_d;
    logic [CNT_W-1:0] seg_q, seg_d;
    logic            ls_meta_q, ls_s_q;
    logic            rdy_en_q;

    logic            push_c, pop_c, flush_c;
    logic [NX_W-1:0] fifo_head;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_cnt;

    // Zero-length segments are acknowledged to the host but never queued.
    assign host_ready = rdy_en_q && (fifo_cnt < CW'(DEPTH)) && !fault_q && !ls_s_q;
    assign push_c     = host_valid && host_ready && (host_data != '0);

    cnc_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (NX_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_c),
        .din_i   (host_data),
        .pop_i   (pop_c),
        .flush_i (flush_c),
        .head_c  (fifo_head),
        .empty_c (fifo_empty),
        .count_o (fifo_cnt)
    );

    // State, strobe timing, outputs and limit-switch synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            nx_q      <= '0;
            wr_q      <= 1'b0;
            fault_q   <= 1'b0;
            seg_q     <= '0;
            ls_meta_q <= 1'b0;
            ls_s_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            nx_q      <= nx_d;
            wr_q      <= wr_d;
            fault_q   <= fault_d;
            seg_q     <= seg_d;
            ls_meta_q <= ls;
            ls_s_q    <= ls_meta_q;
            rdy_en_q  <= 1'b1;
        end
    end

    // Next-state: limit abort overrides everything, else setup/strobe/hold sequencing.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        nx_d    = nx_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        seg_d   = seg_q;
        pop_c   = 1'b0;
        flush_c = 1'b0;

        if (ls_s_q) begin
            state_d = ST_LIMIT;
            tmr_d   = '0;
            nx_d    = '0;
            wr_d    = 1'b0;
            fault_d = 1'b1;
            flush_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    nx_d = '0;
                    wr_d = 1'b0;
                    if (!fifo_empty && !drv_full) begin
                        pop_c   = 1'b1;
                        nx_d    = fifo_head;
                        tmr_d   = '0;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == TMR_W'(SETUP_CYC - 1)) begin
                        tmr_d   = '0;
                        wr_d    = 1'b1;
                        seg_d   = seg_q + CNT_W'(1);
                        state_d = ST_STROBE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (tmr_q == TMR_W'(WR_HIGH_CYC - 1)) begin
                        tmr_d   = '0;
                        wr_d    = 1'b0;
                        state_d = ST_HOLD;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == TMR_W'(HOLD_CYC - 1)) begin
                        tmr_d   = '0;
                        nx_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                ST_LIMIT: begin
                    if (clear_fault) begin
                        fault_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign Nx         = nx_q;
    assign WR         = wr_q;
    assign fault      = fault_q;
    assign seg_count  = seg_q;
    assign fifo_count = fifo_cnt;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    // The strobe must outlast one driver clk1 period so both its domains capture it.
    a_wr_high_len: assert property (@(posedge clk) WR_HIGH_CYC > DRV_CLK1_PERIOD);
    a_depth_pow2:  assert property (@(posedge clk) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));

endmodule
